// File: rtl/fft_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_io_pkg                                                           |
// | Shared state encoding, constants and bit-reversal helper.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fft_io_pkg;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        START  = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    localparam int N_LOG2_DEF = 5;
    localparam int N_SAMPLES  = 1 << N_LOG2_DEF;
    localparam int START_HOLD = 2;

    // Mirrors the low w bits of v; bits at and above w come back zero.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_out_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_out_fifo2                                                        |
// | Two-entry synchronous FIFO holding result words plus their last flag.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_out_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_io_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_io_sequencer                                                     |
// | Loads samples bit-reversed, kicks the FFT core, streams results out. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_io_sequencer
    import fft_io_pkg::*;
#(
    parameter int N_LOG2 = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              start_fft,
    input  logic              fft_done,
    input  logic              result_bank,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_bank,
    output logic [N_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [N_LOG2-1:0] LAST_ADDR = '1;
    localparam logic [1:0]        HOLD_LAST = 2'(START_HOLD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_LOG2-1:0] r_load_cnt;
    logic [N_LOG2-1:0] r_rd_cnt;
    logic [1:0]        r_hold_cnt;
    logic              r_res_bank;
    logic              r_rd_pend;
    logic              r_rd_pend_last;
    logic              r_rd_all;

    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic              w_last_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W:0]   w_fifo_dout;
    logic [1:0]        w_fifo_cnt;
    logic [2:0]        w_occ;
    logic [N_LOG2-1:0] w_load_addr;

    assign in_ready    = (r_state == LOAD);
    assign w_accept    = in_valid && in_ready;
    assign w_load_addr = N_LOG2'(bitrev(16'(r_load_cnt), N_LOG2));

    // Occupancy seen by the next read: stored words plus the read in
    // flight, less the word leaving this cycle.
    assign w_fifo_cnt = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
    assign w_occ      = {1'b0, w_fifo_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue    = (r_state == UNLOAD) && !r_rd_all && (w_occ < 3'd2);

    assign out_valid  = !w_fifo_empty;
    assign out_data   = w_fifo_empty ? '0 : w_fifo_dout[DATA_W-1:0];
    assign out_last   = !w_fifo_empty && w_fifo_dout[DATA_W];
    assign w_pop      = out_valid && out_ready;
    assign w_last_pop = w_pop && w_fifo_dout[DATA_W];
    assign start_fft  = (r_state == START);
    assign busy       = (r_state != LOAD);

    fft_out_fifo2 #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_rd_pend),
        .din   ({r_rd_pend_last, mem_rdata}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_accept && (r_load_cnt == LAST_ADDR)) w_state_nxt = START;
            START:   if (r_hold_cnt == HOLD_LAST) w_state_nxt = ARM;
            ARM:     if (!fft_done) w_state_nxt = RUN;
            RUN:     if (fft_done) w_state_nxt = UNLOAD;
            UNLOAD:  if (w_last_pop) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt     <= '0;
            r_rd_cnt       <= '0;
            r_hold_cnt     <= 2'd0;
            r_res_bank     <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_rd_all       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
            if (r_state == START) begin
                r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? 2'd0 : r_hold_cnt + 2'd1;
            end
            if ((r_state == RUN) && fft_done) begin
                r_res_bank <= result_bank;
            end
            r_rd_pend      <= w_issue;
            r_rd_pend_last <= w_issue && (r_rd_cnt == LAST_ADDR);
            if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (r_rd_cnt == LAST_ADDR) begin
                    r_rd_all <= 1'b1;
                end
            end
            if (w_last_pop) begin
                r_rd_all <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_bank  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_accept) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_load_addr;
            mem_wdata = in_data;
        end else if (w_issue) begin
            mem_en    = 1'b1;
            mem_bank  = r_res_bank;
            mem_addr  = r_rd_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_io_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_io_sequencer                                                  |
// | Scoreboard bench: load, core handshake, unload, mid-unload reset.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fft_io_sequencer;

    localparam int NL = 5;
    localparam int DW = 32;
    localparam int NW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          start_fft;
    logic          fft_done;
    logic          result_bank;
    logic          mem_en;
    logic          mem_we;
    logic          mem_bank;
    logic [NL-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    fft_io_sequencer #(.N_LOG2(NL), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .start_fft   (start_fft),
        .fft_done    (fft_done),
        .result_bank (result_bank),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_bank    (mem_bank),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] brev(input int k);
        logic [NL-1:0] kk;
        logic [NL-1:0] r;
        kk = k[NL-1:0];
        for (int i = 0; i < NL; i++) r[i] = kk[NL-1-i];
        return r;
    endfunction

    // Two-bank memory model; bank 1 stands in for the core's results.
    logic [DW-1:0] bank0 [NW];
    logic [DW-1:0] bank1 [NW];
    initial begin
        for (int a = 0; a < NW; a++) bank1[a] = DW'(a + 100);
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en && mem_we && !mem_bank) bank0[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem_bank ? bank1[mem_addr] : bank0[mem_addr];
    end

    logic [NL+DW-1:0] wq [$];
    logic [DW:0]      oq [$];
    int reads_issued = 0;
    int words_popped = 0;
    int start_run    = 0;

    always @(negedge clk) begin
        logic [NL+DW-1:0] ew;
        logic [DW:0]      eo;
        if (!rst_n) begin
            reads_issued = 0;
            words_popped = 0;
            start_run    = 0;
        end else begin
            if (mem_en && mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    ew = wq.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(ew[NL+DW-1:DW]));
                    check("wr_data", 64'(mem_wdata), 64'(ew[DW-1:0]));
                    check("wr_bank", 64'(mem_bank), 0);
                end
            end
            if (mem_en && !mem_we) begin
                check("rd_bank", 64'(mem_bank), 1);
                check("occupancy_le2", 64'((reads_issued - words_popped) <= 2), 1);
                reads_issued++;
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    eo = oq.pop_front();
                    check("out_data", 64'(out_data), 64'(eo[DW-1:0]));
                    check("out_last", 64'(out_last), 64'(eo[DW]));
                end
                words_popped++;
            end
            if (start_fft) begin
                start_run++;
            end else if (start_run != 0) begin
                check("start_fft_width", 64'(start_run), 2);
                start_run = 0;
            end
        end
    end

    task automatic do_load(input int base);
        for (int k = 0; k < NW; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = DW'(base + k);
            wq.push_back({brev(k), DW'(base + k)});
        end
        @(posedge clk); #1;
        in_data = 32'hDEAD_BEEF;
        check("in_ready_after_load", 64'(in_ready), 0);
        check("busy_after_load", 64'(busy), 1);
    endtask

    task automatic expect_results();
        for (int a = 0; a < NW; a++) oq.push_back({(a == NW - 1), DW'(a + 100)});
    endtask

    int pat [6] = '{1, 0, 0, 1, 1, 0};

    initial begin
        logic done;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; fft_done = 1'b1; result_bank = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_last", 64'(out_last), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_start_fft", 64'(start_fft), 0);
        check("rst_mem_en", 64'(mem_en), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_bank", 64'(mem_bank), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        check("rst_busy", 64'(busy), 0);
        check("brev_1", 64'(brev(1)), 16);
        check("brev_3", 64'(brev(3)), 24);
        @(negedge clk); rst_n = 1'b1;

        // Run 1: stale fft_done, stray in_valid, toggled out_ready.
        do_load(0);
        repeat (8) begin
            @(negedge clk);
            check("stale_done_no_mem", 64'(mem_en), 0);
            check("stale_done_no_out", 64'(out_valid), 0);
        end
        @(posedge clk); #1 fft_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("run_no_write", 64'(mem_en), 0);
        end
        @(posedge clk); #1;
        fft_done = 1'b1; result_bank = 1'b1; in_valid = 1'b0;
        expect_results();
        done = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            out_ready = pat[cyc % 6][0];
            if (cyc == 1) result_bank = 1'b0;
            if (oq.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check("unload1_done", 64'(done), 1);
        check("unload1_word_count", 64'(words_popped), 32);
        check("in_ready_after_unload", 64'(in_ready), 1);

        // Run 2: reset after word 10 of the unload.
        do_load(200);
        repeat (2) @(posedge clk);
        #1 fft_done = 1'b0;
        @(posedge clk); #1;
        fft_done = 1'b1; result_bank = 1'b1; in_valid = 1'b0;
        expect_results();
        done = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (words_popped >= 11) begin
                done = 1'b1;
                break;
            end
        end
        check("reach_word10", 64'(done), 1);
        #1 rst_n = 1'b0;
        #1;
        oq.delete();
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_in_ready", 64'(in_ready), 1);
        check("midrst_mem_en", 64'(mem_en), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_start_fft", 64'(start_fft), 0);
        check("midrst_out_data", 64'(out_data), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_out_valid", 64'(out_valid), 0);
            check("postrst_in_ready", 64'(in_ready), 1);
        end

        // Run 3: a fresh full load is accepted from address bitrev(0).
        do_load(300);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("run3_no_out", 64'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_io_sequencer.md
Name: fft_io_sequencer

Overview:
Host-facing front/back end of the 32-point radix-2 FFT core. It sits directly upstream of the address generation unit: it loads 2^N_LOG2 complex samples into memory bank 0 in bit-reversed order, then issues start_fft. It waits for fft_done, then streams the results out of the bank the core finished in, in natural order.
It owns the memory port whenever the address generation unit is idle.

Parameters:
N_LOG2, 5, log2 of FFT size; sets sample count and address width.
DATA_W, 32, packed complex sample width ({re[15:0], im[15:0]} at the default).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input sample valid.
in_data  input  DATA_W  input sample.
in_ready  output  1  sequencer accepts in_data this cycle.
out_valid  output  1  result sample valid.
out_data  output  DATA_W  result sample.
out_last  output  1  marks the final result sample, index 2^N_LOG2-1.
out_ready  input  1  downstream accepts out_data.
start_fft  output  1  start request to the address generation unit.
fft_done  input  1  completion level from the address generation unit.
result_bank  input  1  bank_select from the address generation unit; names the bank that holds the results.
mem_en  output  1  memory access strobe while the sequencer owns the port.
mem_we  output  1  write enable; qualified by mem_en.
mem_bank  output  1  bank for the access.
mem_addr  output  N_LOG2  word address.
mem_wdata  output  DATA_W  write data.
mem_rdata  input  DATA_W  read data; valid exactly 1 cycle after a read strobe.
busy  output  1  high in every state except LOAD.

Behaviour:
- Reset:
  - Asynchronous reset forces state LOAD and clears all counters.
  - Outputs under reset: in_ready=1, out_valid=0, out_last=0, out_data=0, start_fft=0, mem_en=0, mem_we=0, mem_bank=0, mem_addr=0, mem_wdata=0, busy=0.
- States: LOAD -> START -> ARM -> RUN -> UNLOAD -> LOAD.
- LOAD:
  - A sample is accepted on any cycle with in_valid & in_ready.
  - On the same cycle: mem_en=1, mem_we=1, mem_bank=0, mem_addr=bitrev(load_cnt), mem_wdata=in_data. These are combinational from the handshake.
  - load_cnt increments on each accepted sample.
  - On the accept with load_cnt=2^N_LOG2-1: load_cnt wraps to 0, in_ready drops the next cycle, and the state moves to START.
- START:
  - start_fft=1 for exactly 2 consecutive cycles, then the state moves to ARM.
  - The core edge-detects start_fft through a two-flop delay. start_fft is low in every other state, which guarantees a clean rising edge.
- ARM:
  - fft_done is high while the core idles, so a stale high must not be taken as completion.
  - The sequencer waits until fft_done is sampled low, then moves to RUN.
- RUN:
  - The sequencer waits until fft_done is sampled high.
  - On that cycle it captures result_bank into res_bank_q, then moves to UNLOAD.
  - mem_en=0 throughout START, ARM and RUN; the core owns memory.
- UNLOAD:
  - The sequencer issues reads with mem_en=1, mem_we=0, mem_bank=res_bank_q, mem_addr=rd_cnt (natural order).
  - Read data lands in a 2-entry output FIFO one cycle later.
  - A read is issued only when FIFO occupancy plus reads in flight is less than 2. This makes the FIFO impossible to overflow under any out_ready pattern.
  - out_valid = FIFO not empty. The FIFO pops on out_valid & out_ready.
  - out_last travels with the word read at address 2^N_LOG2-1.
  - The state returns to LOAD on the handshake of the last word. in_ready rises the next cycle.
- Throughput: with out_ready held high, one word per cycle after a first-word latency of 2 cycles from UNLOAD entry.
- Boundary conditions:
  - in_valid while not in LOAD: ignored, in_ready=0.
  - out_ready high while out_valid is low: no effect.
  - If fft_done is already low on ARM entry, ARM lasts one cycle.
  - result_bank changes after capture: no effect.
  - Reset mid-operation, including mid-UNLOAD: FIFO flushed, counters cleared, nothing emitted afterwards until a new full load completes. start_fft drops immediately.
- Arithmetic: load_cnt and rd_cnt are N_LOG2-bit counters with modulo wrap. bitrev mirrors the N_LOG2 bits.

Decomposition:
- Package fft_io_pkg holds:
  - the state enum {LOAD, START, ARM, RUN, UNLOAD};
  - the constants N_SAMPLES=2^N_LOG2 and START_HOLD=2;
  - the bitrev function.
- One sub-module: fft_out_fifo2, a 2-entry synchronous FIFO with async active-low reset, DATA_W+1 bits wide (data plus last), with push/pop/full/empty.

Test Plan:
- Load 32 samples with in_data=k (k=0..31), in_valid always high -> writes occur at mem_addr=bitrev5(k), for example k=1 -> 16 and k=3 -> 24; in_ready=0 from the cycle after k=31.
- After the load completes -> start_fft high for exactly 2 cycles; with a model holding fft_done=1 throughout START, no UNLOAD until fft_done goes low and then high again.
- Model raises fft_done with result_bank=1 while memory bank 1 holds word[a]=a+100 -> out_data sequence 100..131; out_last only on 131; mem_bank=1 on every read.
- out_ready toggled in the pattern 1,0,0,1,1,0 throughout the unload -> no word is lost or duplicated, and FIFO occupancy never exceeds 2.
- rst_n pulsed low after word 10 of the unload -> outputs return to reset values asynchronously, out_valid stays 0, in_ready=1 after release, and a fresh 32-sample load is accepted.
- in_valid asserted during RUN -> no memory write (mem_en=0), and the sample is not counted in the next load.
